intt_addr_gen: RTL



---
 rtl/intt_pkg.sv | 17 +
 rtl/intt_delay_line.sv | 35 +++
 rtl/intt_addr_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/intt_pkg.sv
// Shared types and helpers for the inverse-NTT address sequencer.
// Holds the FSM state encoding and the write-back delay derivation.
package intt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Write-back delay: RAM read latency plus butterfly latency.
    function automatic int wb_dly(input int rd_lat, input int core_lat);
        return rd_lat + core_lat;
    endfunction

endpackage

// File: rtl/intt_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// DEPTH = 0 degenerates to a wire.
module intt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] sr_q [DEPTH];

        // Shift one slot per cycle; clear drops everything in flight.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    sr_q[i] <= '0;
                end
            end else begin
                sr_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/intt_addr_gen.sv
// Coefficient-pair / twiddle address sequencer for one inverse NTT pass.
// Write-back addresses are the read addresses replayed WB_DLY cycles later.
module intt_addr_gen
    import intt_pkg::*;
#(
    parameter int LOG_N    = 10,
    parameter int RD_LAT   = 1,
    parameter int CORE_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       stall,
    output logic                       rd_en,
    output logic [LOG_N-1:0]           rd_addr_a,
    output logic [LOG_N-1:0]           rd_addr_b,
    output logic [LOG_N-2:0]           tw_addr,
    output logic                       wr_en,
    output logic [LOG_N-1:0]           wr_addr_a,
    output logic [LOG_N-1:0]           wr_addr_b,
    output logic [$clog2(LOG_N)-1:0]   stage,
    output logic                       busy,
    output logic                       done
);

    localparam int WB_DLY = wb_dly(RD_LAT, CORE_LAT);
    localparam int JW     = LOG_N - 1;
    localparam int SW     = $clog2(LOG_N);
    localparam int TW     = LOG_N - 1;
    localparam int DW     = (WB_DLY > 1) ? $clog2(WB_DLY) : 1;
    localparam int LW     = 1 + 2 * LOG_N;

    localparam logic [JW-1:0] J_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
    localparam logic [DW-1:0] D_LAST = DW'((WB_DLY > 0) ? WB_DLY - 1 : 0);

    state_e           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [JW-1:0]    j_q, j_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic             stage_end;

    logic [LOG_N-1:0] jx_w, h_w, g_w, k_w, a_w, b_w;
    logic [SW-1:0]    tsh_w;
    logic [TW-1:0]    tw_w;

    logic [LOG_N-1:0] rd_a_q, rd_b_q;
    logic [TW-1:0]    tw_q;
    logic [LW-1:0]    wb_q;

    // Sequencer state, stage and butterfly counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            j_q     <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            drn_q   <= drn_d;
        end
    end

    // Next state, counter updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        j_d       = j_q;
        drn_d     = drn_q;
        stage_end = 1'b0;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!stall) begin
                    rd_en = 1'b1;
                    j_d   = j_q + 1'b1;
                    if (j_q == J_LAST) begin
                        drn_d = '0;
                        if (WB_DLY == 0) begin
                            stage_end = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drn_q == D_LAST) begin
                    stage_end = 1'b1;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
                s_d     = '0;
                j_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (stage_end) begin
            if (s_q == S_LAST) begin
                state_d = ST_DONE;
            end else begin
                s_d     = s_q + 1'b1;
                j_d     = '0;
                state_d = ST_RUN;
            end
        end
    end

    // Pair/twiddle arithmetic on the next-cycle counters.
    always_comb begin
        jx_w  = {1'b0, j_d};
        h_w   = LOG_N'(1) << s_d;
        g_w   = jx_w >> s_d;
        k_w   = jx_w & (h_w - 1'b1);
        a_w   = ((g_w << s_d) << 1) | k_w;
        b_w   = a_w + h_w;
        tsh_w = S_LAST - s_d;
        tw_w  = TW'(k_w << tsh_w);
    end

    // Register the read addresses so they line up with rd_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
            tw_q   <= '0;
        end else begin
            rd_a_q <= a_w;
            rd_b_q <= b_w;
            tw_q   <= tw_w;
        end
    end

    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_addr   = tw_q;
    assign stage     = s_q;

    intt_delay_line #(
        .WIDTH (LW),
        .DEPTH (WB_DLY)
    ) u_wb_dly (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    ({rd_en, rd_a_q, rd_b_q}),
        .q_o    (wb_q)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = wb_q;

endmodule
